// File: rtl/mul_issue_sched.sv
// mul_issue_sched: round-robin multiply issue, flush squash, divider completion sharing.
// Define MUL_ISSUE_SCHED_PERF_EN to add perf_issued/perf_bubbles/perf_squashed counters.
module mul_issue_sched #(
  parameter int LAT = 3,
  parameter int STARVE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       rs_valid,
  output logic [1:0]       rs_ready,
  input  logic [1:0][7:0]  rs_opcode,
  input  logic [1:0][31:0] rs_src_A,
  input  logic [1:0][31:0] rs_src_B,
  input  logic [1:0][63:0] rs_src_hilo,
  input  logic [1:0][4:0]  rs_rob_ptr,
  input  logic [1:0][5:0]  rs_gpr_ptr,
  input  logic [1:0][1:0]  rs_hilo_ptr,
  input  logic             flush,
  output logic             mul_go,
  output logic [7:0]       mul_opcode,
  output logic [31:0]      mul_src_A,
  output logic [31:0]      mul_src_B,
  output logic [63:0]      mul_src_hilo,
  output logic [4:0]       mul_rob_ptr,
  output logic [5:0]       mul_gpr_ptr,
  output logic [1:0]       mul_hilo_ptr,
  input  logic             mul_complete,
  input  logic             div_cpl_req,
  output logic             div_cpl_gnt,
`ifdef MUL_ISSUE_SCHED_PERF_EN
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_bubbles,
  output logic [31:0]      perf_squashed,
`endif
  output logic             cpl_valid
);
  localparam int CW = $clog2(STARVE + 1);
  logic [LAT-1:0] inflight;
  logic [CW-1:0] starve_cnt;
  logic pref, sel, bubble_force, xfer;
  always_comb begin
    bubble_force = starve_cnt == CW'(STARVE);
    sel = &rs_valid ? pref : rs_valid[1];
    xfer = |rs_valid & ~(reset | flush | bubble_force);
    rs_ready = xfer ? (sel ? 2'b10 : 2'b01) : 2'b00;
    cpl_valid = mul_complete & inflight[LAT-1];
    // multiply completion has fixed latency, so it always owns the port when present
    div_cpl_gnt = div_cpl_req & ~inflight[LAT-1] & ~reset;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pref <= 1'b0;
      starve_cnt <= '0;
      inflight <= '0;
      mul_go <= 1'b0;
      mul_opcode <= '0;
      mul_src_A <= '0;
      mul_src_B <= '0;
      mul_src_hilo <= '0;
      mul_rob_ptr <= '0;
      mul_gpr_ptr <= '0;
      mul_hilo_ptr <= '0;
    end else begin
      mul_go <= xfer;
      if (xfer) begin
        pref <= ~sel;
        mul_opcode <= rs_opcode[sel];
        mul_src_A <= rs_src_A[sel];
        mul_src_B <= rs_src_B[sel];
        mul_src_hilo <= rs_src_hilo[sel];
        mul_rob_ptr <= rs_rob_ptr[sel];
        mul_gpr_ptr <= rs_gpr_ptr[sel];
        mul_hilo_ptr <= rs_hilo_ptr[sel];
      end
      inflight <= flush ? '0 : LAT'({inflight, mul_go});
      starve_cnt <= (div_cpl_gnt | flush) ? '0 :
                    (div_cpl_req & ~bubble_force) ? starve_cnt + CW'(1) : starve_cnt;
    end
`ifdef MUL_ISSUE_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_issued <= '0;
      perf_bubbles <= '0;
      perf_squashed <= '0;
    end else begin
      perf_issued <= perf_issued + 32'(xfer);
      perf_bubbles <= perf_bubbles + 32'(bubble_force);
      perf_squashed <= perf_squashed + 32'(mul_complete & ~inflight[LAT-1]);
    end
`endif
endmodule

// File: tb/tb_mul_issue_sched.sv
// tb_mul_issue_sched: random and directed traffic against an issue-time based reference model.
module tb_mul_issue_sched;
  localparam int LAT = 3;
  localparam int STARVE = 4;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] rs_valid, rs_ready;
  logic [1:0][7:0] rs_opcode;
  logic [1:0][31:0] rs_src_A, rs_src_B;
  logic [1:0][63:0] rs_src_hilo;
  logic [1:0][4:0] rs_rob_ptr;
  logic [1:0][5:0] rs_gpr_ptr;
  logic [1:0][1:0] rs_hilo_ptr;
  logic flush, mul_go, mul_complete, div_cpl_req, div_cpl_gnt, cpl_valid;
  logic [7:0] mul_opcode;
  logic [31:0] mul_src_A, mul_src_B;
  logic [63:0] mul_src_hilo;
  logic [4:0] mul_rob_ptr;
  logic [5:0] mul_gpr_ptr;
  logic [1:0] mul_hilo_ptr;
`ifdef MUL_ISSUE_SCHED_PERF_EN
  logic [31:0] perf_issued, perf_bubbles, perf_squashed;
`endif
  mul_issue_sched #(.LAT(LAT), .STARVE(STARVE)) dut (
    .clk(clk), .reset(reset), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .rs_opcode(rs_opcode), .rs_src_A(rs_src_A), .rs_src_B(rs_src_B),
    .rs_src_hilo(rs_src_hilo), .rs_rob_ptr(rs_rob_ptr), .rs_gpr_ptr(rs_gpr_ptr),
    .rs_hilo_ptr(rs_hilo_ptr), .flush(flush), .mul_go(mul_go), .mul_opcode(mul_opcode),
    .mul_src_A(mul_src_A), .mul_src_B(mul_src_B), .mul_src_hilo(mul_src_hilo),
    .mul_rob_ptr(mul_rob_ptr), .mul_gpr_ptr(mul_gpr_ptr), .mul_hilo_ptr(mul_hilo_ptr),
    .mul_complete(mul_complete), .div_cpl_req(div_cpl_req), .div_cpl_gnt(div_cpl_gnt),
`ifdef MUL_ISSUE_SCHED_PERF_EN
    .perf_issued(perf_issued), .perf_bubbles(perf_bubbles), .perf_squashed(perf_squashed),
`endif
    .cpl_valid(cpl_valid)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pref = 0, cnt = 0;
  bit iv = 0;
  logic [148:0] ifld = '0;
  int live[$];
  bit go_at[0:8191];
  logic [31:0] m_issued = 0, m_bubbles = 0, m_squashed = 0;
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [148:0] fld(input int p);
    return {rs_opcode[p], rs_src_A[p], rs_src_B[p], rs_src_hilo[p], rs_rob_ptr[p], rs_gpr_ptr[p], rs_hilo_ptr[p]};
  endfunction
  function automatic logic [148:0] dut_fld();
    return {mul_opcode, mul_src_A, mul_src_B, mul_src_hilo, mul_rob_ptr, mul_gpr_ptr, mul_hilo_ptr};
  endfunction
  function automatic bit mc();
    return cyc >= LAT ? go_at[cyc-LAT] : 1'b0;
  endfunction
  task automatic rnd_fields();
    for (int p = 0; p < 2; p++) begin
      case ($urandom_range(0, 4))
        0: rs_opcode[p] = 8'd12;
        1: rs_opcode[p] = 8'd66;
        2: rs_opcode[p] = 8'd69;
        3: rs_opcode[p] = 8'd68;
        default: rs_opcode[p] = 8'($urandom);
      endcase
      rs_src_A[p] = $urandom;
      rs_src_B[p] = $urandom;
      rs_src_hilo[p] = {$urandom, $urandom};
      rs_rob_ptr[p] = 5'($urandom);
      rs_gpr_ptr[p] = 6'($urandom);
      rs_hilo_ptr[p] = 2'($urandom);
    end
  endtask
  task automatic step(input logic [1:0] v, input bit fl, input bit dreq);
    int g;
    bit occ, bub, dg;
    rs_valid = v;
    flush = fl;
    div_cpl_req = dreq;
    mul_complete = mc();
    #3;
    while (live.size() > 0 && live[0] + LAT < cyc) void'(live.pop_front());
    occ = live.size() > 0 && live[0] == cyc - LAT;
    bub = cnt == STARVE;
    g = (fl || bub || v == 2'b00) ? -1 : (v == 2'b11) ? pref : (v == 2'b01) ? 0 : 1;
    dg = dreq && !occ;
    check("rs_ready", rs_ready, g < 0 ? 2'b00 : (g == 1 ? 2'b10 : 2'b01));
    check("mul_go", mul_go, iv);
    check("mul_data", dut_fld(), ifld);
    check("cpl_valid", cpl_valid, mul_complete && occ);
    check("div_cpl_gnt", div_cpl_gnt, dg);
    go_at[cyc] = iv;
    if (iv) live.push_back(cyc);
    if (fl) live.delete();
    if (bub) m_bubbles++;
    if (mul_complete && !occ) m_squashed++;
    iv = g >= 0;
    if (g >= 0) begin
      ifld = fld(g);
      pref = 1 - g;
      m_issued++;
    end
    cnt = (dg || fl) ? 0 : (dreq && cnt < STARVE) ? cnt + 1 : cnt;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero();
    check("rst_rs_ready", rs_ready, 2'b00);
    check("rst_mul_go", mul_go, 1'b0);
    check("rst_mul_data", dut_fld(), 149'd0);
    check("rst_cpl_valid", cpl_valid, 1'b0);
    check("rst_div_gnt", div_cpl_gnt, 1'b0);
  endtask
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_zero();
    pref = 0; cnt = 0; iv = 0; ifld = '0;
    live.delete();
    m_issued = 0; m_bubbles = 0; m_squashed = 0;
    repeat (2) begin
      go_at[cyc] = 1'b0;
      cyc++;
      @(posedge clk);
      #1;
      mul_complete = mc();
    end
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    rs_valid = 2'b11;
    flush = 1'b0;
    div_cpl_req = 1'b1;
    mul_complete = 1'b0;
    rnd_fields();
    repeat (2) @(posedge clk);
    #1;
    check_zero();
    reset = 1'b0;
    rnd_fields();
    rs_opcode[0] = 8'd12;
    rs_src_A[0] = 32'hFFFFFFFF;
    rs_src_B[0] = 32'd2;
    step(2'b01, 0, 0);
    repeat (5) step(2'b00, 0, 0);
    repeat (6) begin rnd_fields(); step(2'b11, 0, 0); end
    repeat (5) step(2'b00, 0, 0);
    repeat (2) begin rnd_fields(); step(2'b01, 0, 0); end
    step(2'b11, 1, 0);
    repeat (2) step(2'b00, 0, 0);
    rnd_fields();
    step(2'b10, 0, 0);
    repeat (6) step(2'b00, 0, 0);
    repeat (24) begin rnd_fields(); step(2'b11, 0, 1); end
    repeat (5) step(2'b00, 0, 0);
    repeat (3) step(2'b00, 0, 1);
    repeat (3) begin rnd_fields(); step(2'b11, 0, 0); end
    do_reset();
    rnd_fields();
    step(2'b11, 0, 0);
    repeat (5) step(2'b00, 0, 0);
    repeat (600) begin
      rnd_fields();
      step(2'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
    end
    repeat (3) begin rnd_fields(); step(2'b11, 0, 1); end
    do_reset();
    repeat (200) begin
      rnd_fields();
      step(2'($urandom), $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 0);
    end
    repeat (6) step(2'b00, 0, 0);
`ifdef MUL_ISSUE_SCHED_PERF_EN
    check("perf_issued", perf_issued, m_issued);
    check("perf_bubbles", perf_bubbles, m_bubbles);
    check("perf_squashed", perf_squashed, m_squashed);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
